me_frame_sequencer: RTL
=======================

# me_frame_sequencer

Frame-level scheduler for the full-search motion-estimation engine. Walks macroblocks of a frame in raster order and, for each one:
- has the memory loader fill the reference/search memories;
- runs the ME engine by holding its `start` level;
- captures the engine's best vector and distortion;
- hands the result downstream over a valid/ready handshake.

It sits between the frame-buffer loader, the ME controller/PE array, and the motion-vector writer.

## Interface
Parameters:
- MB_COLS, 11, macroblocks per row (1..255)
- MB_ROWS, 9, macroblock rows per frame (1..255)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse, begin a frame
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse after last result accepted
- load_req  out  1  request loader to fill bank load_bank for load_mb_x/y
- load_ack  in  1  one-cycle pulse, load complete
- load_mb_x, load_mb_y  out  8  macroblock coordinates for the load
- load_bank  out  1  bank the loader writes
- bank_sel  out  1  bank the ME engine reads
- me_start  out  1  level start to ME engine; low clears engine counter
- me_done  in  1  one-cycle pulse, engine search complete
- best_vx, best_vy  in  4  engine best vector, two's complement (-8..7)
- best_dist  in  16  engine minimum SAD
- result_valid  out  1  result register full
- result_ready  in  1  downstream accepts result
- result_mb_x, result_mb_y  out  8  coordinates of result
- result_vx, result_vy  out  4  captured vector
- result_dist  out  16  captured SAD

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE: frame_start -> LOAD with position (0,0), busy=1. frame_start ignored in every other state.
- LOAD:
  - load_req high, load_mb_x/y stable until load_ack is sampled.
  - On ack: load_req low, then -> RUN.
- RUN:
  - me_start high until me_done is sampled.
  - On me_done:
    - capture best_vx/vy/dist and current coordinates into the result register; result_valid=1.
    - me_start=0, then -> DRAIN.
- DRAIN: wait for result_valid && result_ready. Then:
  - result_valid=0.
  - Last macroblock (MB_COLS-1, MB_ROWS-1): frame_done pulse, busy=0, -> IDLE.
  - Otherwise: advance position and -> LOAD.
- Raster advance: x+1; at x=MB_COLS-1, x wraps to 0 and y+1.
- Result outputs hold stable while result_valid=1 && !result_ready.
- me_start is never high while result_valid=1. This guarantees me_start is low for at least one cycle between runs.
- Ignored inputs, no state change: me_done outside RUN, load_ack while load_req=0.
- MB_COLS=MB_ROWS=1: single load/run/drain, then frame_done.

## Timing
- Reset (asynchronous, any state): all outputs 0, bank_sel=0, load_bank=0, FSM=IDLE, position (0,0). Pending handshakes are abandoned.
- frame_start at cycle t -> busy and load_req high at t+1.
- load_ack at cycle a -> load_req low and me_start high at a+1.
- me_done at cycle m -> me_start low and result_valid high at m+1.
- Handshake at cycle r:
  - next load_req at r+1 (serial mode), or frame_done at r+1 for the last macroblock.
  - frame_done is high for exactly one cycle; a frame_start arriving in the frame_done cycle is ignored.
- Serial per-macroblock overhead beyond loader and engine time: 3 cycles.

## Configuration
- ME_PREFETCH_EN defined:
  - Ping-pong operation. On entering RUN for any macroblock except the last, load_req for the next position is issued in the same cycle, with load_bank = ~bank_sel. A prefetch-done flag records load_ack.
  - On the DRAIN handshake:
    - flag set: toggle bank_sel, clear flag, me_start high at r+1 (LOAD skipped).
    - flag clear: stay in LOAD until load_ack, then toggle and run.
  - load_ack for the prefetch may arrive in any state from RUN to LOAD.
- Not defined:
  - Strictly serial as above.
  - bank_sel and load_bank are constant 0.

## Test plan
- Reset: assert reset_n=0 mid-frame -> every output 0 in the same cycle; frame_start after release restarts at (0,0).
- Serial frame, MB_COLS=2, MB_ROWS=2, immediate ack/ready:
  - load coordinates (0,0),(1,0),(0,1),(1,1) in that order.
  - Four results carrying injected vectors, e.g. vx=-8 (4'h8), vy=7, dist=16'h1234.
  - A single frame_done one cycle after the 4th handshake.
- Backpressure: result_ready low for 10 cycles -> result_* stable, me_start and load_req stay low. Handshake resumes the sequence at r+1.
- Spurious inputs: frame_start while busy, me_done during LOAD, load_ack with no request -> no state, coordinate or output change.
- Latency check: ack at cycle a -> me_start at a+1. me_done at m -> result_valid at m+1, me_start low at m+1.
- With ME_PREFETCH_EN, 2x1 frame:
  - second load_req (1,0) with load_bank=1 in the same cycle as the first me_start.
  - Ack received before first drain -> bank_sel flips 0->1 and me_start rises at r+1.
  - No third load_req.

Source files
------------

// File: rtl/me_frame_sequencer.sv
// Frame-level macroblock scheduler: loader -> ME engine -> result register, raster order.
// Latency: load_req 1 cycle after frame_start/handshake, me_start 1 cycle after load_ack, result 1 cycle after me_done.
// Backpressure: result register holds while result_ready is low; no new load or run starts until it drains.
// Optional feature macro: ME_PREFETCH_EN (ping-pong bank prefetch of the next macroblock during RUN).
module me_frame_sequencer #(
  parameter int MB_COLS = 11,
  parameter int MB_ROWS = 9
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        load_req,
  input  logic        load_ack,
  output logic [7:0]  load_mb_x,
  output logic [7:0]  load_mb_y,
  output logic        load_bank,
  output logic        bank_sel,
  output logic        me_start,
  input  logic        me_done,
  input  logic [3:0]  best_vx,
  input  logic [3:0]  best_vy,
  input  logic [15:0] best_dist,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [7:0]  result_mb_x,
  output logic [7:0]  result_mb_y,
  output logic [3:0]  result_vx,
  output logic [3:0]  result_vy,
  output logic [15:0] result_dist
);

  localparam logic [7:0] LAST_X = 8'(MB_COLS - 1);
  localparam logic [7:0] LAST_Y = 8'(MB_ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t     state;
  logic [7:0] cur_x, cur_y;
  logic [7:0] nxt_x, nxt_y;
  logic       cur_last;
  logic       ack_hit;

  // Raster successor of (x,y): packed as {y, x}
  function automatic logic [15:0] advance(input logic [7:0] x, input logic [7:0] y);
    if (x == LAST_X) return {8'(y + 8'd1), 8'd0};
    else             return {y, 8'(x + 8'd1)};
  endfunction

  // Position bookkeeping shared by both build flavours
  always_comb begin
    {nxt_y, nxt_x} = advance(cur_x, cur_y);
    cur_last       = (cur_x == LAST_X) && (cur_y == LAST_Y);
    ack_hit        = load_ack && load_req;
  end

`ifdef ME_PREFETCH_EN
  logic       pf_done;
  logic [7:0] nn_x, nn_y;
  logic       nxt_last;

  // Prefetch target once the position advances past the current macroblock
  always_comb begin
    {nn_y, nn_x} = advance(nxt_x, nxt_y);
    nxt_last     = (nxt_x == LAST_X) && (nxt_y == LAST_Y);
  end
`else
  assign load_bank = 1'b0;
  assign bank_sel  = 1'b0;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cur_x        <= 8'd0;
      cur_y        <= 8'd0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      load_req     <= 1'b0;
      load_mb_x    <= 8'd0;
      load_mb_y    <= 8'd0;
      me_start     <= 1'b0;
      result_valid <= 1'b0;
      result_mb_x  <= 8'd0;
      result_mb_y  <= 8'd0;
      result_vx    <= 4'd0;
      result_vy    <= 4'd0;
      result_dist  <= 16'd0;
`ifdef ME_PREFETCH_EN
      load_bank    <= 1'b0;
      bank_sel     <= 1'b0;
      pf_done      <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the frame_done pulse is not a new frame
          if (frame_start && !frame_done) begin
            state     <= LOAD;
            busy      <= 1'b1;
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
            load_req  <= 1'b1;
            load_mb_x <= 8'd0;
            load_mb_y <= 8'd0;
`ifdef ME_PREFETCH_EN
            load_bank <= 1'b0;
            bank_sel  <= 1'b0;
            pf_done   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (ack_hit) begin
            load_req <= 1'b0;
            me_start <= 1'b1;
            state    <= RUN;
`ifdef ME_PREFETCH_EN
            // Engine reads the bank just filled; next load goes to the other one
            bank_sel <= load_bank;
            if (!cur_last) begin
              load_req  <= 1'b1;
              load_mb_x <= nxt_x;
              load_mb_y <= nxt_y;
              load_bank <= ~load_bank;
            end
`endif
          end
        end
        RUN: begin
`ifdef ME_PREFETCH_EN
          if (ack_hit) begin
            load_req <= 1'b0;
            pf_done  <= 1'b1;
          end
`endif
          if (me_done) begin
            me_start     <= 1'b0;
            result_valid <= 1'b1;
            result_mb_x  <= cur_x;
            result_mb_y  <= cur_y;
            result_vx    <= best_vx;
            result_vy    <= best_vy;
            result_dist  <= best_dist;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
`ifdef ME_PREFETCH_EN
          if (ack_hit) begin
            load_req <= 1'b0;
            pf_done  <= 1'b1;
          end
`endif
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            if (cur_last) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              cur_x <= nxt_x;
              cur_y <= nxt_y;
`ifdef ME_PREFETCH_EN
              // An ack landing in the handshake cycle counts as already prefetched
              if (pf_done || ack_hit) begin
                bank_sel <= ~bank_sel;
                pf_done  <= 1'b0;
                me_start <= 1'b1;
                state    <= RUN;
                if (!nxt_last) begin
                  load_req  <= 1'b1;
                  load_mb_x <= nn_x;
                  load_mb_y <= nn_y;
                  load_bank <= bank_sel;
                end
              end else begin
                state <= LOAD;
              end
`else
              load_req  <= 1'b1;
              load_mb_x <= nxt_x;
              load_mb_y <= nxt_y;
              state     <= LOAD;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
